// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/MEM memory-port arbiter and the
// pipeline stages that generate its requests.
package mem_port_arbiter_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    // Width of the starvation counter; STARVE_LIMIT must fit (1..15).
    localparam int CNT_W = 4;

    // Major opcodes shared with control_unit for MEM-stage request generation.
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2,
        IF_DROP = 2'd3
    } arb_state_e;

    function automatic logic is_mem_opcode(input logic [6:0] opc);
        return (opc == OPC_LOAD) || (opc == OPC_STORE);
    endfunction

    function automatic logic is_store(input logic [6:0] opc);
        return opc == OPC_STORE;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between fetch, MEM stage, the arbiter and the memory.
// slave = arbiter side; master = the requesters plus memory around it.
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;
    logic              if_stall;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ack;
    logic              dm_stall;

    logic              flush;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, flush,
               mem_rdata, mem_ready,
        output if_rdata, if_ack, if_stall, dm_rdata, dm_ack, dm_stall,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, flush,
               mem_rdata, mem_ready,
        input  if_rdata, if_ack, if_stall, dm_rdata, dm_ack, dm_stall,
               mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating count of data grants taken while a fetch is waiting; a fetch
// grant clears it.
module mem_port_arbiter_starve_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_limit_o
);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        // NOTE: default first so every path assigns cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LIMIT_C)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking so every flop updates from pre-edge values together.
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit_o = (cnt_q == LIMIT_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the MEM stage,
// with data priority, fetch anti-starvation and flush squashing of fetches.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_port_arbiter_if.slave    bus
);
    arb_state_e        state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              if_ack_q, if_ack_d;
    logic              dm_ack_q, dm_ack_d;

    logic              if_elig;
    logic              dm_elig;
    logic              cnt_inc;
    logic              cnt_clr;
    logic              starve_at_limit;

    mem_port_arbiter_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc_i      (cnt_inc),
        .clr_i      (cnt_clr),
        .at_limit_o (starve_at_limit)
    );

    // A requester acked this cycle is still holding req; it must not re-win.
    assign if_elig = bus.if_req & ~if_ack_q & ~bus.flush;
    assign dm_elig = bus.dm_req & ~dm_ack_q;

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_ack_d    = 1'b0;
        dm_ack_d    = 1'b0;
        cnt_inc     = 1'b0;
        cnt_clr     = 1'b0;

        case (state_q)
            IDLE: begin
                mem_req_d = 1'b0;
                if (dm_elig && !(if_elig && starve_at_limit)) begin
                    state_d     = DM_BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.dm_we;
                    mem_addr_d  = bus.dm_addr;
                    mem_wdata_d = bus.dm_wdata;
                    cnt_inc     = bus.if_req;
                end else if (if_elig) begin
                    state_d    = IF_BUSY;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = bus.if_addr;
                    cnt_clr    = 1'b1;
                end
            end

            IF_BUSY: begin
                if (bus.mem_ready) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    if (!bus.flush) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = bus.mem_rdata;
                    end
                end else if (bus.flush) begin
                    state_d = IF_DROP;
                end
            end

            DM_BUSY: begin
                if (bus.mem_ready) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    dm_ack_d  = 1'b1;
                    if (!mem_we_q) begin
                        dm_rdata_d = bus.mem_rdata;
                    end
                end
            end

            IF_DROP: begin
                if (bus.mem_ready) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end
            end

            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_ack_q    <= if_ack_d;
            dm_ack_q    <= dm_ack_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.dm_ack    = dm_ack_q;
    assign bus.if_stall  = bus.if_req & ~if_ack_q;
    assign bus.dm_stall  = bus.dm_req & ~dm_ack_q;

endmodule
